// File: rtl/sat_bin_pkg.sv
// Shared types and defaults for the SAT bin manager: sequencer states, default word widths
// and a one-hot helper.
package sat_bin_pkg;

    localparam int unsigned WIDTH_CLAUSES    = 16;
    localparam int unsigned WIDTH_VAR_STATES = 19;
    localparam int unsigned WIDTH_BIN_ID     = 10;
    localparam int unsigned ONEHOT_MAX       = 64;

    typedef enum logic [2:0] {
        StIdle,
        StLdC,
        StLdV,
        StUpC,
        StUpV,
        StDone
    } bin_state_e;

    // Returns a vector with only bit idx set, or all zeros when idx is outside 0..n-1.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx,
                                                     input int unsigned n);
        logic [ONEHOT_MAX-1:0] v;
        v = '0;
        if (idx < n && idx < ONEHOT_MAX) begin
            v = ONEHOT_MAX'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/bin_load_update_ctrl.sv
// Moves one bin between the clause / var-state RAMs and the SAT core: load streams RAM into
// the core one entry per cycle, update reads the core back and writes it to RAM.
module bin_load_update_ctrl #(
    parameter int unsigned NUM_CLAUSES_A_BIN      = 8,
    parameter int unsigned NUM_VARS_A_BIN         = 8,
    parameter int unsigned WIDTH_BIN_ID           = sat_bin_pkg::WIDTH_BIN_ID,
    parameter int unsigned WIDTH_CLAUSES          = NUM_VARS_A_BIN * 2,
    parameter int unsigned WIDTH_VAR_STATES       = sat_bin_pkg::WIDTH_VAR_STATES,
    parameter int unsigned ADDR_WIDTH_CLAUSES     = 9,
    parameter int unsigned ADDR_WIDTH_VARS_STATES = 9
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start_load_i,
    input  logic                                       start_update_i,
    input  logic [WIDTH_BIN_ID-1:0]                    bin_id_i,
    output logic                                       busy_o,
    output logic                                       done_o,
    output logic [ADDR_WIDTH_CLAUSES-1:0]              ram_addr_c_o,
    output logic                                       ram_we_c_o,
    output logic [WIDTH_CLAUSES-1:0]                   ram_din_c_o,
    input  logic [WIDTH_CLAUSES-1:0]                   ram_dout_c_i,
    output logic [ADDR_WIDTH_VARS_STATES-1:0]          ram_addr_vs_o,
    output logic                                       ram_we_vs_o,
    output logic [WIDTH_VAR_STATES-1:0]                ram_din_vs_o,
    input  logic [WIDTH_VAR_STATES-1:0]                ram_dout_vs_i,
    output logic [NUM_CLAUSES_A_BIN-1:0]               wr_carray_o,
    output logic [WIDTH_CLAUSES-1:0]                   clause_o,
    output logic [NUM_CLAUSES_A_BIN-1:0]               rd_carray_o,
    input  logic [WIDTH_CLAUSES-1:0]                   clause_i,
    output logic [NUM_VARS_A_BIN-1:0]                  wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] vars_states_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] vars_states_i
);

    import sat_bin_pkg::*;

    localparam int unsigned N       = NUM_CLAUSES_A_BIN;
    localparam int unsigned V       = NUM_VARS_A_BIN;
    localparam int unsigned AC      = ADDR_WIDTH_CLAUSES;
    localparam int unsigned AV      = ADDR_WIDTH_VARS_STATES;
    localparam int unsigned WV      = WIDTH_VAR_STATES;
    localparam int unsigned CNT_MAX = (N > V) ? N : V;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    bin_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [AC-1:0]       cb_q, cb_d, cb_new;
    logic [AV-1:0]       vb_q, vb_d, vb_new;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [AC-1:0]       addr_c_q, addr_c_d;
    logic                we_c_q, we_c_d;
    logic [AV-1:0]       addr_vs_q, addr_vs_d;
    logic                we_vs_q, we_vs_d;
    logic [WV-1:0]       din_vs_q, din_vs_d;
    logic [N-1:0]        wr_c_q, wr_c_d;
    logic [N-1:0]        rd_c_q, rd_c_d;
    logic [WIDTH_CLAUSES-1:0] clause_q, clause_d;
    logic [V-1:0]        wr_vs_q, wr_vs_d;
    logic [WV*V-1:0]     vs_q, vs_d;
    logic [ONEHOT_MAX-1:0] oh;
    int unsigned         cur;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cb_d      = cb_q;
        vb_d      = vb_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        addr_c_d  = '0;
        we_c_d    = 1'b0;
        addr_vs_d = '0;
        we_vs_d   = 1'b0;
        din_vs_d  = '0;
        wr_c_d    = '0;
        rd_c_d    = '0;
        wr_vs_d   = '0;
        clause_d  = clause_q;
        vs_d      = vs_q;
        oh        = '0;
        cur       = 32'(cnt_q);
        cb_new    = AC'(32'(bin_id_i) * N);
        vb_new    = AV'(32'(bin_id_i) * V);

        unique case (state_q)
            StIdle: begin
                // done_q high means this is the completion cycle; starts wait one more cycle.
                if (!done_q && start_load_i) begin
                    state_d  = StLdC;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    cb_d     = cb_new;
                    vb_d     = vb_new;
                    addr_c_d = cb_new;
                end else if (!done_q && start_update_i) begin
                    state_d = StUpC;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    cb_d    = cb_new;
                    vb_d    = vb_new;
                    oh      = onehot(0, N);
                    rd_c_d  = oh[N-1:0];
                end
            end

            StLdC: begin
                if (cur + 1 < N) begin
                    addr_c_d = cb_q + AC'(cur + 1);
                end
                if (cur >= 1) begin
                    clause_d = ram_dout_c_i;
                    oh       = onehot(cur - 1, N);
                    wr_c_d   = oh[N-1:0];
                end
                if (cur == N) begin
                    state_d   = StLdV;
                    cnt_d     = '0;
                    addr_vs_d = vb_q;
                end else begin
                    cnt_d = CNT_W'(cur + 1);
                end
            end

            StLdV: begin
                if (cur + 1 < V) begin
                    addr_vs_d = vb_q + AV'(cur + 1);
                end
                if (cur >= 1) begin
                    vs_d[(cur - 1) * WV +: WV] = ram_dout_vs_i;
                    oh      = onehot(cur - 1, V);
                    wr_vs_d = oh[V-1:0];
                end
                if (cur == V) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = CNT_W'(cur + 1);
                end
            end

            StUpC: begin
                if (cur + 1 < N) begin
                    oh     = onehot(cur + 1, N);
                    rd_c_d = oh[N-1:0];
                end
                if (cur < N) begin
                    we_c_d   = 1'b1;
                    addr_c_d = cb_q + AC'(cur);
                end
                if (cur == N) begin
                    state_d   = StUpV;
                    cnt_d     = '0;
                    we_vs_d   = 1'b1;
                    addr_vs_d = vb_q;
                    din_vs_d  = vars_states_i[0 +: WV];
                end else begin
                    cnt_d = CNT_W'(cur + 1);
                end
            end

            StUpV: begin
                if (cur + 1 < V) begin
                    we_vs_d   = 1'b1;
                    addr_vs_d = vb_q + AV'(cur + 1);
                    din_vs_d  = vars_states_i[(cur + 1) * WV +: WV];
                    cnt_d     = CNT_W'(cur + 1);
                end else begin
                    state_d = StDone;
                    cnt_d   = '0;
                end
            end

            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cb_q      <= '0;
            vb_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_c_q  <= '0;
            we_c_q    <= 1'b0;
            addr_vs_q <= '0;
            we_vs_q   <= 1'b0;
            din_vs_q  <= '0;
            wr_c_q    <= '0;
            rd_c_q    <= '0;
            clause_q  <= '0;
            wr_vs_q   <= '0;
            vs_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cb_q      <= cb_d;
            vb_q      <= vb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            addr_c_q  <= addr_c_d;
            we_c_q    <= we_c_d;
            addr_vs_q <= addr_vs_d;
            we_vs_q   <= we_vs_d;
            din_vs_q  <= din_vs_d;
            wr_c_q    <= wr_c_d;
            rd_c_q    <= rd_c_d;
            clause_q  <= clause_d;
            wr_vs_q   <= wr_vs_d;
            vs_q      <= vs_d;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign ram_addr_c_o    = addr_c_q;
    assign ram_we_c_o      = we_c_q;
    // Core clause data arrives one cycle after rd_carray_o, exactly when its write is issued.
    assign ram_din_c_o     = we_c_q ? clause_i : '0;
    assign ram_addr_vs_o   = addr_vs_q;
    assign ram_we_vs_o     = we_vs_q;
    assign ram_din_vs_o    = din_vs_q;
    assign wr_carray_o     = wr_c_q;
    assign clause_o        = clause_q;
    assign rd_carray_o     = rd_c_q;
    assign wr_var_states_o = wr_vs_q;
    assign vars_states_o   = vs_q;

endmodule

// File: tb/tb_bin_load_update_ctrl.sv
// Scoreboard bench for bin_load_update_ctrl: stimulus pushes expected events, a negedge monitor
// pops and compares them against what the DUT presents.
module tb_bin_load_update_ctrl;
    import sat_bin_pkg::*;

    localparam int N     = 8;
    localparam int V     = 8;
    localparam int WC    = WIDTH_CLAUSES;
    localparam int WV    = WIDTH_VAR_STATES;
    localparam int WB    = WIDTH_BIN_ID;
    localparam int AC    = 9;
    localparam int AV    = 9;
    localparam int DEPTH = 512;
    localparam int DW    = WV * V;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start_load_i, start_update_i;
    logic [WB-1:0] bin_id_i;
    logic          busy_o, done_o;
    logic [AC-1:0] ram_addr_c_o;
    logic          ram_we_c_o;
    logic [WC-1:0] ram_din_c_o, ram_dout_c_i;
    logic [AV-1:0] ram_addr_vs_o;
    logic          ram_we_vs_o;
    logic [WV-1:0] ram_din_vs_o, ram_dout_vs_i;
    logic [N-1:0]  wr_carray_o, rd_carray_o;
    logic [WC-1:0] clause_o, clause_i;
    logic [V-1:0]  wr_var_states_o;
    logic [DW-1:0] vars_states_o, vars_states_i;

    bin_load_update_ctrl #(
        .NUM_CLAUSES_A_BIN(N), .NUM_VARS_A_BIN(V), .WIDTH_BIN_ID(WB), .WIDTH_CLAUSES(WC),
        .WIDTH_VAR_STATES(WV), .ADDR_WIDTH_CLAUSES(AC), .ADDR_WIDTH_VARS_STATES(AV)
    ) dut (
        .clk(clk), .rst(rst), .start_load_i(start_load_i), .start_update_i(start_update_i),
        .bin_id_i(bin_id_i), .busy_o(busy_o), .done_o(done_o),
        .ram_addr_c_o(ram_addr_c_o), .ram_we_c_o(ram_we_c_o), .ram_din_c_o(ram_din_c_o),
        .ram_dout_c_i(ram_dout_c_i), .ram_addr_vs_o(ram_addr_vs_o), .ram_we_vs_o(ram_we_vs_o),
        .ram_din_vs_o(ram_din_vs_o), .ram_dout_vs_i(ram_dout_vs_i), .wr_carray_o(wr_carray_o),
        .clause_o(clause_o), .rd_carray_o(rd_carray_o), .clause_i(clause_i),
        .wr_var_states_o(wr_var_states_o), .vars_states_o(vars_states_o),
        .vars_states_i(vars_states_i)
    );

    typedef struct {
        int            cyc;
        logic [31:0]   a;
        logic [DW-1:0] d;
    } ev_t;

    ev_t q_wc[$], q_wv[$], q_rd[$], q_rc[$], q_rv[$], q_done[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [WC-1:0] mem_c[DEPTH], ref_c[DEPTH];
    logic [WV-1:0] mem_v[DEPTH], ref_v[DEPTH];
    logic [WC-1:0] core_c[N];
    logic [WV-1:0] core_v[V];
    logic [DW-1:0] exp_bus;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Environment: RAMs with one-cycle read latency and a core with registered clause read.
    always @(posedge clk) begin
        ram_dout_c_i  <= mem_c[ram_addr_c_o];
        ram_dout_vs_i <= mem_v[ram_addr_vs_o];
        if (ram_we_c_o) mem_c[ram_addr_c_o] <= ram_din_c_o;
        if (ram_we_vs_o) mem_v[ram_addr_vs_o] <= ram_din_vs_o;
        clause_i <= '0;
        for (int k = 0; k < N; k++) if (rd_carray_o[k]) clause_i <= core_c[k];
    end

    always_comb begin
        vars_states_i = '0;
        for (int j = 0; j < V; j++) vars_states_i[j*WV +: WV] = core_v[j];
    end

    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            if (wr_carray_o != '0) begin
                if (q_wc.size() == 0) chk("wr_carray_unexpected", DW'(wr_carray_o), '0);
                else begin
                    e = q_wc.pop_front();
                    chk("wr_carray_cycle", DW'(cyc), DW'(e.cyc));
                    chk("wr_carray_strobe", DW'(wr_carray_o), DW'(e.a));
                    chk("clause_o", DW'(clause_o), e.d);
                end
            end
            if (wr_var_states_o != '0) begin
                if (q_wv.size() == 0) chk("wr_vs_unexpected", DW'(wr_var_states_o), '0);
                else begin
                    e = q_wv.pop_front();
                    chk("wr_vs_cycle", DW'(cyc), DW'(e.cyc));
                    chk("wr_vs_strobe", DW'(wr_var_states_o), DW'(e.a));
                    chk("vars_states_o", vars_states_o, e.d);
                end
            end
            if (rd_carray_o != '0) begin
                if (q_rd.size() == 0) chk("rd_carray_unexpected", DW'(rd_carray_o), '0);
                else begin
                    e = q_rd.pop_front();
                    chk("rd_carray_cycle", DW'(cyc), DW'(e.cyc));
                    chk("rd_carray_strobe", DW'(rd_carray_o), DW'(e.a));
                end
            end
            if (ram_we_c_o) begin
                if (q_rc.size() == 0) chk("ram_we_c_unexpected", DW'(ram_addr_c_o), '1);
                else begin
                    e = q_rc.pop_front();
                    chk("ram_c_wr_cycle", DW'(cyc), DW'(e.cyc));
                    chk("ram_c_wr_addr", DW'(ram_addr_c_o), DW'(e.a));
                    chk("ram_c_wr_data", DW'(ram_din_c_o), e.d);
                end
            end
            if (ram_we_vs_o) begin
                if (q_rv.size() == 0) chk("ram_we_vs_unexpected", DW'(ram_addr_vs_o), '1);
                else begin
                    e = q_rv.pop_front();
                    chk("ram_vs_wr_cycle", DW'(cyc), DW'(e.cyc));
                    chk("ram_vs_wr_addr", DW'(ram_addr_vs_o), DW'(e.a));
                    chk("ram_vs_wr_data", DW'(ram_din_vs_o), e.d);
                end
            end
            if (done_o) begin
                done_cnt++;
                if (q_done.size() == 0) chk("done_unexpected", DW'(done_o), '0);
                else begin
                    e = q_done.pop_front();
                    chk("done_cycle", DW'(cyc), DW'(e.cyc));
                    chk("done_busy_low", DW'(busy_o), '0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy_done"}, DW'({busy_o, done_o}), '0);
        chk({tag, "_strobes"}, DW'({wr_carray_o, rd_carray_o, wr_var_states_o, ram_we_c_o,
                                    ram_we_vs_o}), '0);
        chk({tag, "_addrs"}, DW'({ram_addr_c_o, ram_addr_vs_o}), '0);
        chk({tag, "_data"}, DW'({clause_o, ram_din_c_o, ram_din_vs_o}), '0);
        chk({tag, "_vars_states_o"}, vars_states_o, '0);
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (done_cnt == prev && n < 100) begin
            tick();
            n++;
        end
        if (done_cnt == prev) chk("done_timeout", DW'(done_cnt), DW'(prev + 1));
    endtask

    task automatic do_load(input int bin, input bit both, input bit poke_upd);
        int  base, prev, a;
        ev_t e;
        prev = done_cnt;
        start_load_i   = 1'b1;
        start_update_i = both;
        bin_id_i       = WB'(bin);
        base = cyc + 1;
        for (int i = 0; i < N; i++) begin
            a = (bin * N + i) % DEPTH;
            e.cyc = base + 2 + i; e.a = 32'(1) << i; e.d = DW'(ref_c[a]);
            q_wc.push_back(e);
        end
        for (int j = 0; j < V; j++) begin
            a = (bin * V + j) % DEPTH;
            exp_bus[j*WV +: WV] = ref_v[a];
            e.cyc = base + N + 3 + j; e.a = 32'(1) << j; e.d = exp_bus;
            q_wv.push_back(e);
        end
        e.cyc = base + N + V + 3; e.a = '0; e.d = '0;
        q_done.push_back(e);
        tick();
        start_load_i   = 1'b0;
        start_update_i = 1'b0;
        bin_id_i       = WB'($urandom);
        chk("busy_rise_load", DW'(busy_o), DW'(1));
        if (poke_upd) begin
            repeat (5) tick();
            start_update_i = 1'b1;
            tick();
            start_update_i = 1'b0;
        end
        wait_done(prev);
    endtask

    task automatic do_update(input int bin, input int abort_k, input bit rnd_core);
        int  base, prev, a;
        ev_t e;
        prev = done_cnt;
        if (rnd_core) begin
            for (int k = 0; k < N; k++) core_c[k] = WC'($urandom);
            for (int j = 0; j < V; j++) core_v[j] = WV'($urandom);
        end
        start_update_i = 1'b1;
        bin_id_i       = WB'(bin);
        base = cyc + 1;
        for (int k = 0; k < N; k++) begin
            if (abort_k < 0 || k < abort_k) begin
                e.cyc = base + k; e.a = 32'(1) << k; e.d = '0;
                q_rd.push_back(e);
            end
            // A write lands on the edge after it is presented; the abort cuts the last one.
            if (abort_k < 0 || k < abort_k - 1) begin
                a = (bin * N + k) % DEPTH;
                ref_c[a] = core_c[k];
                e.cyc = base + k + 1; e.a = 32'(a); e.d = DW'(core_c[k]);
                q_rc.push_back(e);
            end
        end
        if (abort_k < 0) begin
            for (int j = 0; j < V; j++) begin
                a = (bin * V + j) % DEPTH;
                ref_v[a] = core_v[j];
                e.cyc = base + N + 1 + j; e.a = 32'(a); e.d = DW'(core_v[j]);
                q_rv.push_back(e);
            end
            e.cyc = base + N + V + 2; e.a = '0; e.d = '0;
            q_done.push_back(e);
        end
        tick();
        start_update_i = 1'b0;
        bin_id_i       = WB'($urandom);
        chk("busy_rise_update", DW'(busy_o), DW'(1));
        if (abort_k < 0) begin
            wait_done(prev);
        end else begin
            while (cyc < base + abort_k) tick();
            #1 rst = 1'b0;
            #1 check_reset_outputs("abort");
            exp_bus = '0;
            tick();
            tick();
            rst = 1'b1;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int mc, mv;
        start_load_i   = 1'b0;
        start_update_i = 1'b0;
        bin_id_i       = '0;
        exp_bus        = '0;
        for (int a = 0; a < DEPTH; a++) begin
            v = $urandom;
            mem_c[a] <= v[WC-1:0];
            ref_c[a] = v[WC-1:0];
            v = $urandom;
            mem_v[a] <= v[WV-1:0];
            ref_v[a] = v[WV-1:0];
        end
        for (int k = 0; k < N; k++) core_c[k] = WC'(16'hC000 + k);
        for (int j = 0; j < V; j++) core_v[j] = WV'(19'h05500 + j);
        #1 rst = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_c[16+i] <= WC'(16'h0100 + i);
            ref_c[16+i] = WC'(16'h0100 + i);
            mem_v[16+i] <= WV'(19'h00A00 + i);
            ref_v[16+i] = WV'(19'h00A00 + i);
        end
        tick();

        do_load(2, 1'b0, 1'b0);
        do_update(3, -1, 1'b0);
        do_load(1, 1'b1, 1'b0);
        do_load(5, 1'b0, 1'b1);
        do_update(6, 4, 1'b1);
        do_load(0, 1'b0, 1'b0);
        do_load(63, 1'b0, 1'b0);
        do_update(64, -1, 1'b1);
        do_load(64, 1'b0, 1'b0);
        do_load(3, 1'b0, 1'b0);
        repeat (12) begin
            if ($urandom_range(1) == 1) do_load(int'($urandom_range(1023)), 1'b0, 1'b0);
            else do_update(int'($urandom_range(1023)), -1, 1'b1);
        end
        repeat (3) tick();

        chk("q_wr_carray_left", DW'(q_wc.size()), '0);
        chk("q_wr_vs_left", DW'(q_wv.size()), '0);
        chk("q_rd_carray_left", DW'(q_rd.size()), '0);
        chk("q_ram_c_wr_left", DW'(q_rc.size()), '0);
        chk("q_ram_vs_wr_left", DW'(q_rv.size()), '0);
        chk("q_done_left", DW'(q_done.size()), '0);
        mc = 0;
        mv = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (mem_c[a] !== ref_c[a]) mc++;
            if (mem_v[a] !== ref_v[a]) mv++;
        end
        chk("ram_c_contents_bad_words", DW'(mc), '0);
        chk("ram_vs_contents_bad_words", DW'(mv), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
